// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation codes and width for the registered ALU slice
package alu_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

endpackage

// File: rtl/addsub32_core.sv
// rtl/addsub32_core.sv - ripple-carry adder/subtractor, sub inverts b and injects carry-in
module addsub32_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] b_eff;
   logic             carry;

   assign b_eff = b ^ {WIDTH{sub}};

   // Carry kept in a procedural variable so the chain is not one self-referencing vector
   always_comb begin
      sum   = '0;
      carry = sub;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b_eff[i] ^ carry;
         carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/mux2x32_sel.sv
// rtl/mux2x32_sel.sv - 2:1 word multiplexer, s=0 selects a
module mux2x32_sel #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/alu32_reg.sv
// rtl/alu32_reg.sv - registered add/sub/and/or ALU slice with Z/V/C flags and valid strobe
module alu32_reg
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic             En,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [1:0]       Aluc,
   output logic [WIDTH-1:0] R,
   output logic             Z,
   output logic             V,
   output logic             C,
   output logic             Vld
);

   logic [WIDTH-1:0] as_sum;
   logic             as_cout;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] r_c;
   logic             arith;
   logic             zc;
   logic             vc;
   logic             cc;

   addsub32_core #(.WIDTH(WIDTH)) u_addsub (
      .a    (X),
      .b    (Y),
      .sub  (Aluc[0]),
      .sum  (as_sum),
      .cout (as_cout)
   );

   mux2x32_sel #(.WIDTH(WIDTH)) u_logic_mux (
      .a (X & Y),
      .b (X | Y),
      .s (Aluc[0]),
      .y (logic_res)
   );

   mux2x32_sel #(.WIDTH(WIDTH)) u_result_mux (
      .a (as_sum),
      .b (logic_res),
      .s (Aluc[1]),
      .y (r_c)
   );

   assign arith = (Aluc == ALU_ADD) || (Aluc == ALU_SUB);
   assign zc    = ~|r_c;
   // Operand signs must agree for add, differ for sub, before a sign flip counts as overflow
   assign vc    = arith && ((X[WIDTH-1] ^ Y[WIDTH-1]) == Aluc[0]) && (r_c[WIDTH-1] != X[WIDTH-1]);
   assign cc    = arith && as_cout;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         R   <= '0;
         Z   <= 1'b0;
         V   <= 1'b0;
         C   <= 1'b0;
         Vld <= 1'b0;
      end else begin
         Vld <= En;
         if (En) begin
            R <= r_c;
            Z <= zc;
            V <= vc;
            C <= cc;
         end
      end
   end

endmodule

// File: tb/tb_alu32_reg.sv
// tb/tb_alu32_reg.sv - directed and randomized checks of alu32_reg against an arithmetic reference
module tb_alu32_reg;

   typedef struct packed {
      logic [31:0] r;
      logic        z;
      logic        v;
      logic        c;
   } res_t;

   logic        Clk;
   logic        Clrn;
   logic        En;
   logic [31:0] X;
   logic [31:0] Y;
   logic [1:0]  Aluc;
   logic [31:0] R;
   logic        Z;
   logic        V;
   logic        C;
   logic        Vld;

   int n_checks = 0;
   int n_fail   = 0;

   alu32_reg #(.WIDTH(32)) dut (
      .Clk  (Clk),
      .Clrn (Clrn),
      .En   (En),
      .X    (X),
      .Y    (Y),
      .Aluc (Aluc),
      .R    (R),
      .Z    (Z),
      .V    (V),
      .C    (C),
      .Vld  (Vld)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic res_t ref_alu(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
      res_t   o;
      longint u;
      longint s;
      o = '0;
      case (op)
         2'd0: begin
            u   = longint'(x) + longint'(y);
            s   = longint'($signed(x)) + longint'($signed(y));
            o.r = x + y;
            o.c = (u >= 64'sd4294967296);
            o.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         2'd1: begin
            s   = longint'($signed(x)) - longint'($signed(y));
            o.r = x - y;
            o.c = (x >= y);
            o.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         2'd2: o.r = x & y;
         default: o.r = x | y;
      endcase
      o.z = (o.r == 32'd0);
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [31:0] r, input logic z, input logic v,
                             input logic c, input logic vld);
      check({tag, ".R"}, R, r);
      check({tag, ".Z"}, {31'd0, Z}, {31'd0, z});
      check({tag, ".V"}, {31'd0, V}, {31'd0, v});
      check({tag, ".C"}, {31'd0, C}, {31'd0, c});
      check({tag, ".Vld"}, {31'd0, Vld}, {31'd0, vld});
   endtask

   task automatic cycle(input logic en, input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
      @(negedge Clk);
      En   = en;
      X    = x;
      Y    = y;
      Aluc = op;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [31:0] corners [6];
      res_t        m;
      logic        mvld;
      logic        en;
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  op;

      corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
      Clrn = 1'b1; En = 1'b0; X = '0; Y = '0; Aluc = 2'b00;
      #2 Clrn = 1'b0;
      #1 expect_out("reset", 32'h0, 0, 0, 0, 0);
      @(negedge Clk);
      Clrn = 1'b1;

      cycle(1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b00); expect_out("add_f0", 32'hFFFFFFFF, 0, 0, 0, 1);
      cycle(1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b01); expect_out("sub_f0", 32'hE1E1E1E1, 0, 0, 1, 1);
      cycle(1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b10); expect_out("and_f0", 32'h00000000, 1, 0, 0, 1);
      cycle(1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b11); expect_out("or_f0", 32'hFFFFFFFF, 0, 0, 0, 1);
      cycle(1, 32'h7FFFFFFF, 32'h00000001, 2'b00); expect_out("add_ovf", 32'h80000000, 0, 1, 0, 1);
      cycle(1, 32'h80000000, 32'h00000001, 2'b01); expect_out("sub_ovf", 32'h7FFFFFFF, 0, 1, 1, 1);
      cycle(1, 32'hFFFFFFFF, 32'h00000001, 2'b00); expect_out("add_wrap", 32'h00000000, 1, 0, 1, 1);
      cycle(1, 32'h12345678, 32'h12345678, 2'b01); expect_out("sub_eq", 32'h00000000, 1, 0, 1, 1);

      cycle(1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b01); expect_out("load", 32'hE1E1E1E1, 0, 0, 1, 1);
      cycle(0, 32'h7FFFFFFF, 32'h00000001, 2'b00); expect_out("hold1", 32'hE1E1E1E1, 0, 0, 1, 0);
      cycle(0, 32'h00000000, 32'h00000000, 2'b10); expect_out("hold2", 32'hE1E1E1E1, 0, 0, 1, 0);
      cycle(1, 32'h00000001, 32'h00000002, 2'b00); expect_out("reen", 32'h00000003, 0, 0, 0, 1);

      cycle(1, 32'h7FFFFFFF, 32'h00000001, 2'b00); expect_out("pre_rst", 32'h80000000, 0, 1, 0, 1);
      #2 Clrn = 1'b0;
      #1 expect_out("async_rst", 32'h0, 0, 0, 0, 0);
      @(posedge Clk); #1;
      expect_out("rst_held", 32'h0, 0, 0, 0, 0);
      @(negedge Clk);
      Clrn = 1'b1;
      En   = 1'b0;
      @(posedge Clk); #1;
      expect_out("rst_release", 32'h0, 0, 0, 0, 0);
      cycle(1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b01); expect_out("post_rst", 32'hE1E1E1E1, 0, 0, 1, 1);

      m    = ref_alu(32'hF0F0F0F0, 32'h0F0F0F0F, 2'b01);
      mvld = 1'b1;
      for (int i = 0; i < 60; i++) begin
         en = ($urandom_range(0, 4) != 0);
         x  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
         y  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
         op = 2'($urandom_range(0, 3));
         cycle(en, x, y, op);
         if (en) m = ref_alu(x, y, op);
         mvld = en;
         expect_out($sformatf("rnd%0d", i), m.r, m.z, m.v, m.c, mvld);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu32_reg.md
Name: alu32_reg

Overview:
- Registered 32-bit integer ALU slice for the single-cycle/pipelined CPU datapath.
- Performs add, subtract, AND and OR on two operands, and produces result, zero, overflow and carry flags.
- Built from a 32-bit adder/subtractor and 2:1 32-bit word multiplexers.
- Outputs are registered, one cycle after the operands are accepted.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is required to be supported; V and C use bit WIDTH-1 as the sign bit.

Ports:
- Clk  input  1  rising-edge clock
- Clrn  input  1  reset, asynchronous, active-low
- En  input  1  operands valid; capture result this edge
- X  input  32  operand A
- Y  input  32  operand B
- Aluc  input  2  operation select: 00 add, 01 sub, 10 and, 11 or
- R  output  32  registered result
- Z  output  1  registered zero flag, 1 when R == 0
- V  output  1  registered signed-overflow flag
- C  output  1  registered carry/no-borrow flag
- Vld  output  1  registered result-valid strobe

Behaviour:
- Reset: Clrn low forces R=0, Z=0, V=0, C=0, Vld=0 immediately, independent of Clk. Deassertion takes effect at the next rising Clk.
- Adder/subtractor: computes X + (Y XOR {32{Aluc[0]}}) + Aluc[0] as a 33-bit sum.
  - Sub therefore equals X - Y in two's complement.
  - Result wraps modulo 2^32.
- Logic path: Aluc[0]=0 selects X&Y; Aluc[0]=1 selects X|Y.
- Result mux: Aluc[1]=0 selects the add/sub result; Aluc[1]=1 selects the logic result.
- Combinational zero flag: Zc = NOR of all 32 bits of the selected result. This applies to every operation.
- Combinational overflow flag Vc:
  - add: X[31]==Y[31] and Rc[31]!=X[31].
  - sub: X[31]!=Y[31] and Rc[31]!=X[31].
  - logic ops: 0.
- Combinational carry flag Cc:
  - add/sub: bit 32 of the adder sum. For sub, 1 means no borrow (X >= Y unsigned).
  - logic ops: 0.
- Latency is one cycle. At a rising Clk with En=1: R<=Rc, Z<=Zc, V<=Vc, C<=Cc, Vld<=1.
- At a rising Clk with En=0: R, Z, V and C hold their values; Vld<=0.
- Back-to-back En=1 cycles give one result per cycle. There is no stall and no backpressure.
- Aluc and the operands are sampled only at the clock edge. Changes between edges have no effect on the outputs.
- If reset is asserted mid-stream, the in-flight result is discarded and the outputs are cleared at once.
- No X/Z propagation is allowed from the unused path. Both datapaths are always computed and then muxed.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11;
  - WIDTH default constant.
- Sub-module addsub32_core:
  - inputs a, b, sub; outputs sum[31:0] and cout;
  - implemented as a ripple-carry chain or 4-bit carry-lookahead groups.
- Sub-module mux2x32_sel: 2:1 word mux, s=0 selects input a. It is instantiated twice, for the logic select and the result select.
- Flag logic and output registers live in the top module.

Test Plan:
- X=F0F0F0F0, Y=0F0F0F0F, En=1, Aluc=00 -> next cycle R=FFFFFFFF, Z=0, V=0, C=0, Vld=1.
- Same operands, Aluc=01 -> R=E1E1E1E1, Z=0, V=0, C=1. Aluc=10 -> R=00000000, Z=1, V=0, C=0. Aluc=11 -> R=FFFFFFFF, Z=0.
- Overflow and carry cases:
  - X=7FFFFFFF, Y=00000001, add -> R=80000000, V=1, C=0.
  - X=80000000, Y=00000001, sub -> R=7FFFFFFF, V=1, C=1.
  - X=FFFFFFFF, Y=00000001, add -> R=0, Z=1, C=1, V=0.
- Load R=E1E1E1E1, then drive En=0 with new operands -> R/Z/V/C unchanged and Vld=0. Re-assert En -> new result is captured one cycle later.
- Assert Clrn=0 asynchronously, between clock edges, while outputs are nonzero -> R=0, Z=0, V=0, C=0, Vld=0 immediately. They stay 0 until the first En=1 edge after release.
- X=Y=12345678, sub -> R=0, Z=1, C=1, V=0. Back-to-back add/sub/and/or on consecutive cycles -> each result appears exactly one cycle after its inputs.
